// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result bus and nibble-wide adder bus of the serial add controller.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic [3:0]   add_x;
    logic [3:0]   add_y;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

    // Controller side.
    modport slave (
        input  start, a, b, cin, add_sum, add_cout,
        output busy, done, result, cout, zero, add_x, add_y, add_cin
    );

    // Requester plus adder side.
    modport master (
        output start, a, b, cin, add_sum, add_cout,
        input  busy, done, result, cout, zero, add_x, add_y, add_cin
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two W-bit operands one nibble per cycle through an external 4-bit adder,
// LSB nibble first, rippling the carry in a register and pulsing done on completion.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic                     clk,
    input logic                     rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          cin_q;
    logic          carry_q;
    logic [W-1:0]  partial_q;
    logic [W-1:0]  result_q;
    logic          cout_q;
    logic          zero_q;
    logic          busy_q;
    logic          done_q;

    logic [W-1:0]  sum_d;
    logic          last_nibble;

    // Partial result fills from the top so that after NIBBLES shifts nibble 0 sits at the bottom.
    assign sum_d       = {bus.add_sum, partial_q[W-1:4]};
    assign last_nibble = (idx_q == IW'(NIBBLES - 1));

    // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            carry_q   <= 1'b0;
            partial_q <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        cin_q   <= bus.cin;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q       <= a_q >> 4;
                    b_q       <= b_q >> 4;
                    carry_q   <= bus.add_cout;
                    partial_q <= sum_d;
                    idx_q     <= idx_q + 1'b1;
                    if (last_nibble) begin
                        result_q <= sum_d;
                        cout_q   <= bus.add_cout;
                        zero_q   <= (sum_d == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: defaults first keep this block free of inferred latches.
    always_comb begin
        bus.add_x   = 4'h0;
        bus.add_y   = 4'h0;
        bus.add_cin = 1'b0;
        if (state_q == RUN) begin
            bus.add_x   = a_q[3:0];
            bus.add_y   = b_q[3:0];
            bus.add_cin = (idx_q == '0) ? cin_q : carry_q;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized scoreboard bench for nibble_serial_add_ctrl with an arithmetic reference model.
module tb_nibble_serial_add_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();
    nibble_serial_add_ctrl_if #(.NIBBLES(2)) bus2 ();

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    nibble_serial_add_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Behavioural 4-bit adders.
    assign {bus.add_cout, bus.add_sum}   = {1'b0, bus.add_x} + {1'b0, bus.add_y} + 5'(bus.add_cin);
    assign {bus2.add_cout, bus2.add_sum} = {1'b0, bus2.add_x} + {1'b0, bus2.add_y} + 5'(bus2.add_cin);

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        int           done_edge;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge counter, accepted operation and held result.
    int           cnt = 0;
    bit           have_op = 1'b0;
    int           op_e = 0;
    longint       op_a = 0, op_b = 0, op_cin = 0;
    logic [W-1:0] ref_res = '0;
    logic         ref_cout = 1'b0;
    logic         ref_zero = 1'b1;

    always @(posedge clk) begin
        longint full;
        cnt++;
        if (rst) begin
            have_op  = 1'b0;
            sb_q.delete();
            ref_res  = '0;
            ref_cout = 1'b0;
            ref_zero = 1'b1;
        end else begin
            if (have_op && cnt == op_e + N) begin
                full     = op_a + op_b + op_cin;
                ref_res  = W'(full);
                ref_cout = full[W];
                ref_zero = (ref_res == '0);
            end
            if (bus.start && (!have_op || cnt >= op_e + N + 1)) begin
                have_op = 1'b1;
                op_e    = cnt;
                op_a    = longint'(bus.a);
                op_b    = longint'(bus.b);
                op_cin  = longint'(bus.cin);
                full    = op_a + op_b + op_cin;
                sb_q.push_back('{res: W'(full), cout: full[W], zero: (W'(full) == '0),
                                 done_edge: cnt + N});
            end
        end
    end

    // Monitor: per-cycle checks of adder drive and status, scoreboard pop on done.
    always @(negedge clk) begin
        int     k;
        bit     in_run;
        longint mask, exp_cin;
        exp_t   e;
        if (cnt > 0) begin
            k       = cnt - op_e;
            in_run  = have_op && k >= 0 && k < N;
            exp_cin = 0;
            if (in_run) begin
                mask    = (64'd1 << (4 * k)) - 1;
                exp_cin = (k == 0) ? op_cin
                                   : (((op_a & mask) + (op_b & mask) + op_cin) >> (4 * k)) & 1;
            end
            check("busy", bus.busy, in_run);
            check("done", bus.done, have_op && cnt == op_e + N);
            check("result_held", bus.result, ref_res);
            check("cout_held", bus.cout, ref_cout);
            check("zero_held", bus.zero, ref_zero);
            check("add_x", bus.add_x, in_run ? (op_a >> (4 * k)) & 15 : 0);
            check("add_y", bus.add_y, in_run ? (op_b >> (4 * k)) & 15 : 0);
            check("add_cin", bus.add_cin, exp_cin);
            if (bus.done) begin
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_result", bus.result, e.res);
                    check("sb_cout", bus.cout, e.cout);
                    check("sb_zero", bus.zero, e.zero);
                    check("sb_latency", cnt, e.done_edge);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        bus.start = s;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        bus.start  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Full carry ripple into cout with zero result.
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        idle(6);
        // Distinct nibbles with carry-in.
        drive(1'b1, 16'h1234, 16'h4321, 1'b1);
        idle(6);
        // start during RUN is ignored.
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b1, 16'hAAAA, 16'hAAAA, 1'b1);
        drive(1'b1, 16'hAAAA, 16'hAAAA, 1'b1);
        idle(4);
        // Back-to-back acceptance from DONE.
        drive(1'b1, 16'h0001, 16'h0001, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h8000, 16'h8000, 1'b0);
        idle(8);
        // Reset in RUN cycle 3, then a normal run.
        drive(1'b1, 16'h1234, 16'h4321, 1'b1);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        drive(1'b1, 16'h1111, 16'h2222, 1'b0);
        idle(6);

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 60) == 0);
            drive($urandom_range(0, 2) == 0, W'($urandom), W'($urandom), 1'($urandom));
        end
        rst = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
        check("sb_drained", sb_q.size(), 0);
        idle(2);

        // Two-nibble instance: 0xFF + 0xFF + 1.
        bus2.start = 1'b1; bus2.a = 8'hFF; bus2.b = 8'hFF; bus2.cin = 1'b1;
        step();
        bus2.start = 1'b0;
        check("n2_busy_c1", bus2.busy, 1);
        check("n2_add_x_c1", bus2.add_x, 4'hF);
        check("n2_add_cin_c1", bus2.add_cin, 1);
        step();
        check("n2_busy_c2", bus2.busy, 1);
        check("n2_add_cin_c2", bus2.add_cin, 1);
        check("n2_done_c2", bus2.done, 0);
        step();
        check("n2_done_c3", bus2.done, 1);
        check("n2_busy_c3", bus2.busy, 0);
        check("n2_result", bus2.result, 8'hFF);
        check("n2_cout", bus2.cout, 1);
        check("n2_zero", bus2.zero, 0);
        step();
        check("n2_done_c4", bus2.done, 0);
        check("n2_result_hold", bus2.result, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencing stage that sits directly upstream of the 4-bit Manchester carry adder: it feeds it and consumes its result.
- Adds two wide operands over several cycles, one 4-bit nibble per cycle, LSB nibble first.
- Each cycle it drives the adder's x, y and carry_in, then captures the adder's sum and carry_out.
- Ripples carry between cycles in a register, assembles the wide result, and reports completion with a done pulse.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- cin  input  1  carry into nibble 0, captured on accepted start
- busy  output  1  high while nibbles are being issued
- done  output  1  one-cycle pulse: result/cout/zero freshly valid
- result  output  W  registered sum, held until next completion
- cout  output  1  carry out of the top nibble, held with result
- zero  output  1  high when result == 0, held with result
- add_x  output  4  to adder x
- add_y  output  4  to adder y
- add_cin  output  1  to adder carry_in
- add_sum  input  4  from adder sum, combinational response to add_x/add_y/add_cin
- add_cout  input  1  from adder carry_out

Behaviour:
- Reset (rst=1 at an edge):
  - state IDLE; busy=0, done=0, result=0, cout=0, zero=1.
  - Nibble index, operand shift registers and carry register all cleared.
  - Overrides any operation in progress; no done pulse follows.
- FSM states:
  - IDLE: start=1 → capture a, b, cin; idx=0; go to RUN.
  - RUN: busy=1. Each edge: write add_sum into partial slot idx; carry_reg<=add_cout; idx++. At idx==NIBBLES-1, go to DONE and load result, cout and zero from the completed partial value and add_cout.
  - DONE: done=1, busy=0, lasts one cycle. start=1 → behave as IDLE acceptance (back-to-back, no bubble). Otherwise go to IDLE.
- Adder drive:
  - In RUN: add_x=A[4*idx+3:4*idx], add_y=B[4*idx+3:4*idx].
  - add_cin = captured cin when idx==0, else carry_reg.
  - Outside RUN: add_x=0, add_y=0, add_cin=0.
- Latency:
  - start sampled at edge E0.
  - RUN occupies cycles 1..NIBBLES.
  - done=1 in cycle NIBBLES+1, i.e. 5 cycles after start for NIBBLES=4.
  - Throughput with continuous start: one result per NIBBLES+1 cycles.
- start while in RUN is ignored. Captured operands and cin are unaffected by later changes on a, b or cin.
- result, cout and zero change only on entry to DONE or on reset. They are stable in all other cycles.
- Arithmetic: {cout,result} = a + b + cin, modulo 2^(W+1). No signed-overflow flag.
- The adder is treated as purely combinational within one cycle; no multicycle path.

Test Plan:
- NIBBLES=4, a=0xFFFF, b=0x0001, cin=0 → add_cin sequence 0,1,1,1; result=0x0000, cout=1, zero=1; done exactly in cycle 5, busy high cycles 1–4.
- a=0x1234, b=0x4321, cin=1 → add_x per RUN cycle 4,3,2,1; add_y 1,2,3,4; result=0x5556, cout=0, zero=0.
- start with a=0x00FF, b=0x0001, then start=1 with a=0xAAAA during RUN cycle 2 → second start ignored; result=0x0100; no second done.
- Back-to-back: start held high continuously with 0x0001+0x0001, then 0x8000+0x8000 → done in cycles 5 and 10; results 0x0002/cout0, then 0x0000/cout1.
- rst asserted in RUN cycle 3 → next cycle busy=0, done=0, result=0, cout=0, zero=1, add_x/add_y/add_cin=0; no done pulse; a new start runs normally.
- NIBBLES=2, 0xFF+0xFF, cin=1 → result=0xFF, cout=1, done in cycle 3.
